conv3x3_window_gen: RTL
=======================

Name: conv3x3_window_gen

Overview:
Streaming 3x3 sliding-window generator that sits directly upstream of the 9-lane SD4 MAC. It accepts one 8-bit pixel per handshake in raster order and keeps two line buffers plus a 3x3 register window. For every valid-padding output position it presents a packed 72-bit window, aligned with a latched 36-bit weight kernel. It supports output backpressure, and it flags frame and window boundaries.

Parameters:
IMG_W, 28, pixels per image row (min 3)
IMG_H, 28, rows per frame (min 3)
PIX_W, 8, bits per pixel; window width = 9*PIX_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
pix_in  input  PIX_W  incoming pixel, raster order
in_valid  input  1  pix_in valid
in_ready  output  1  block can accept pix_in this cycle
weight_in  input  36  nine 4-bit SD4 weights, lane k at [4k+3:4k]
weight_load  input  1  latch weight_in
image  output  9*PIX_W  window, lane k at [PIX_W*k+PIX_W-1:PIX_W*k]
weight  output  36  latched kernel, feeds the MAC alongside image
out_valid  output  1  image/weight hold a valid window
out_ready  input  1  consumer takes window
out_last  output  1  qualifies out_valid: last window of frame
frame_done  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (rst=1 at clk edge): col=0, row=0, out_valid=0, out_last=0, frame_done=0, image=0, weight=0. in_ready reads 1 in the first cycle after reset.
- Line-buffer contents are don't-care after reset; the row/col gating below masks them.
- Accept: a pixel is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational), i.e. a single-entry output skid.
- On accept: the pixel enters the window and line buffers, then col increments.
  - col==IMG_W-1 -> col=0, row increments.
  - row==IMG_H-1 && col==IMG_W-1 -> row=0, col=0, and frame_done=1 on the next cycle.
- Window generation: when the accepted pixel sits at (row,col) with row>=2 && col>=2, then on the next cycle out_valid=1 and image holds rows row-2..row and columns col-2..col.
- Lane index k = 3*r + c, with r=0 the oldest (top) row and c=0 the leftmost column.
- No window straddles a row or frame boundary. Windows per frame = (IMG_W-2)*(IMG_H-2).
- out_last=1 together with the window for pixel (IMG_H-1, IMG_W-1).
- Latency: 1 cycle from accept of the completing pixel to out_valid.
- Hold: while out_valid && !out_ready, image, out_last and out_valid are stable and no pixel is accepted.
- On out_valid && out_ready with no new window completing, out_valid drops to 0 on the next cycle.
- On out_valid && out_ready with a new completing pixel accepted in the same cycle, the new window loads back-to-back, so out_valid stays 1.
- Throughput: 1 pixel/cycle when out_ready is held at 1.
- Weights: weight_load=1 -> weight <= weight_in on the next edge, independent of the pixel handshake.
  - weight_load is applied even while a window is stalled; the consumer sees the new kernel with the held window.
  - Upstream control must load weights only between frames.
- frame_done is asserted for exactly one cycle per frame, regardless of out_ready.
- Reset mid-frame: all counters and flags clear on the next edge. Any pending window is discarded. The next accepted pixel is treated as (0,0) of a fresh frame.
- in_valid=0 gaps: no state change except output drain. Gaps may occur anywhere, including across row wrap.

Test Plan:
- IMG_W=IMG_H=4, pix=4*row+col, out_ready=1, in_valid=1 continuous -> first out_valid one cycle after pixel 10 is accepted. Expected image=0x0A0908060504020100.
- Same run, all windows -> exactly 4 windows, with image lane 8 values 10,11,14,15. out_last only on the 15 window; frame_done pulses once, the cycle after pixel 15.
- Backpressure: out_ready=0 for 5 cycles when the first window appears -> in_ready=0. The window stays 0x0A0908060504020100 and no pixels are lost. The next window (lane 8=11) follows after out_ready rises.
- Two back-to-back frames, second with pix+0x40 -> no window mixes frames. The first window of frame 2 has lane 0 = 0x40.
- weight_load with weight_in=0x123456789 -> weight=0x123456789 on the next cycle and is held until the next load.
- rst=1 after pixel 6 of a frame, then restart from pixel 0 -> outputs are zero during reset. The first window is again 0x0A0908060504020100, with no stale data.

Source files
------------

// File: rtl/conv3x3_window_gen_if.sv
// Pixel-in / window-out handshake bundle for the 3x3 window generator.
interface conv3x3_window_gen_if #(
    parameter int unsigned PIX_W = 8
);
    logic [PIX_W-1:0]   pix_in;
    logic               in_valid;
    logic               in_ready;
    logic [35:0]        weight_in;
    logic               weight_load;
    logic [9*PIX_W-1:0] image;
    logic [35:0]        weight;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               frame_done;

    modport slave (
        input  pix_in, in_valid, weight_in, weight_load, out_ready,
        output in_ready, image, weight, out_valid, out_last, frame_done
    );

    modport master (
        output pix_in, in_valid, weight_in, weight_load, out_ready,
        input  in_ready, image, weight, out_valid, out_last, frame_done
    );
endinterface

// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 valid-padding window generator: two line buffers, a 3x2 history
// window and a single-entry output register aligned with a latched SD4 kernel.
module conv3x3_window_gen #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    conv3x3_window_gen_if.slave bus
);
    localparam int unsigned CW    = $clog2(IMG_W);
    localparam int unsigned RW    = $clog2(IMG_H);
    localparam int unsigned WIN_W = 9 * PIX_W;
    localparam int unsigned KW    = 36;

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PIX_W-1:0] lb_top [IMG_W];
    logic [PIX_W-1:0] lb_mid [IMG_W];
    logic [PIX_W-1:0] win    [3][2];
    logic [WIN_W-1:0] image_q;
    logic [KW-1:0]    weight_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             frame_done_q;

    logic             in_ready_c;
    logic             accept_c;
    logic             col_last_c;
    logic             row_last_c;
    logic             win_done_c;
    logic [PIX_W-1:0] new_col_c [3];
    logic [WIN_W-1:0] win_img_c;

    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign col_last_c = (col == CW'(IMG_W - 1));
    assign row_last_c = (row == RW'(IMG_H - 1));
    assign win_done_c = (row >= RW'(2)) && (col >= CW'(2));

    // Column entering the window: rows r-2, r-1 from line buffers, row r live.
    always_comb begin
        new_col_c[0] = lb_top[col];
        new_col_c[1] = lb_mid[col];
        new_col_c[2] = bus.pix_in;
        win_img_c    = '0;
        for (int r = 0; r < 3; r++) begin
            win_img_c[PIX_W*(3*r+0) +: PIX_W] = win[r][0];
            win_img_c[PIX_W*(3*r+1) +: PIX_W] = win[r][1];
            win_img_c[PIX_W*(3*r+2) +: PIX_W] = new_col_c[r];
        end
    end

    // Pixel storage needs no reset: row/col gating masks stale contents.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb_top[col] <= new_col_c[1];
            lb_mid[col] <= bus.pix_in;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= new_col_c[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            image_q      <= '0;
            weight_q     <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept_c && col_last_c && row_last_c;
            if (bus.weight_load) begin
                weight_q <= bus.weight_in;
            end
            if (accept_c) begin
                if (col_last_c) begin
                    col <= '0;
                    row <= row_last_c ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            // Output skid: load on completing pixel, else drain on consume.
            if (accept_c && win_done_c) begin
                image_q     <= win_img_c;
                out_valid_q <= 1'b1;
                out_last_q  <= col_last_c && row_last_c;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.image      = image_q;
    assign bus.weight     = weight_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.frame_done = frame_done_q;
endmodule
